rv_fetch_queue: RTL and testbench



---
 rtl/rv_fetch_queue.sv | 134 +++++++++++++
 tb/tb_rv_fetch_queue.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_queue.sv
// RV32I fetch front end: PC generator, in-order imem request/response interface and a
// DEPTH-entry prefetch FIFO with redirect flush and misaligned-target fault reporting.
module rv_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic [31:0]     if_instr,
  output logic            if_fault
);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, FPUSH, HALT} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   count, outst, drop;
  logic [XLEN-1:0] fetch_pc, fault_pc;

  // PCs of issued requests, consumed in order as kept responses return
  logic [XLEN-1:0] ipc_q [DEPTH];
  logic [PW-1:0]   ipc_wr, ipc_rd;

  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] fault_q;
  logic [PW-1:0]    rd_ptr, wr_ptr;

  logic            issue, resp_keep, resp_drop, fault_push, push, pop;
  logic [XLEN-1:0] push_pc;
  logic [31:0]     push_instr;
  logic            push_fault;
  logic [CW:0]     in_use;

  always_comb begin
    in_use     = {1'b0, count} + {1'b0, outst} + {1'b0, drop};
    issue      = (state == RUN) && !redirect_valid && (in_use < DEPTH_W);
    resp_drop  = imem_rvalid && (drop != '0);
    resp_keep  = imem_rvalid && (drop == '0) && (state == RUN);
    fault_push = (state == FPUSH) && (drop == '0);
    pop        = if_valid && if_ready && !redirect_valid;
    push       = !redirect_valid && (resp_keep || fault_push);
    push_pc    = fault_push ? fault_pc : ipc_q[ipc_rd];
    push_instr = fault_push ? NOP : imem_rdata;
    push_fault = fault_push;

    state_nxt = state;
    if (redirect_valid)
      state_nxt = (redirect_pc[1:0] != 2'b00) ? FPUSH : RUN;
    else if (fault_push)
      state_nxt = HALT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // A redirect moves every in-flight request into the drop count, less any response
  // landing in the same cycle, and discards the matching PC FIFO entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      fault_pc <= RESET_PC;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
      ipc_wr   <= '0;
      ipc_rd   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      fault_pc <= redirect_pc;
      count    <= '0;
      wr_ptr   <= rd_ptr;
      drop     <= drop + outst - CW'(imem_rvalid);
      outst    <= '0;
      ipc_rd   <= ipc_wr;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        ipc_wr   <= ipc_wr + PW'(1);
      end
      if (resp_keep) ipc_rd <= ipc_rd + PW'(1);
      if (resp_drop) drop   <= drop - CW'(1);
      outst <= outst + CW'(issue) - CW'(resp_keep);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) ipc_q[ipc_wr] <= fetch_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[PW'(i)]    <= RESET_PC;
        instr_q[PW'(i)] <= NOP;
      end
      fault_q <= '0;
    end else if (push) begin
      pc_q[wr_ptr]    <= push_pc;
      instr_q[wr_ptr] <= push_instr;
      fault_q[wr_ptr] <= push_fault;
    end
  end

  assign imem_req  = issue && !reset;
  assign imem_addr = fetch_pc;
  assign if_valid  = (count != '0);
  assign if_pc     = pc_q[rd_ptr];
  assign if_instr  = instr_q[rd_ptr];
  assign if_fault  = fault_q[rd_ptr];
  assign if_pc4    = if_pc + XLEN'(4);

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Self-checking bench for rv_fetch_queue: in-order latency memory model plus a
// queue-based model of the delivered instruction stream.
module tb_rv_fetch_queue;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc, if_pc4, if_instr;
  logic        if_fault;

  always #5 clk = ~clk;

  rv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_pc4(if_pc4),
    .if_instr(if_instr), .if_fault(if_fault)
  );

  typedef struct { logic [31:0] addr; int unsigned due; int unsigned epoch; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } ent_t;

  req_t        mem_q[$];
  ent_t        exp_q[$];
  int unsigned cyc = 0, lat = 1, jitter = 0, epoch = 0, pops = 0;
  logic [31:0] next_addr = RST_PC;
  bit          running = 1'b1;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
  endfunction

  // Advance to just after the next rising edge and present this cycle's memory response.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // Mid-cycle: check DUT against the model, then apply this cycle's events to the model.
  task automatic half();
    ent_t e;
    req_t r;
    bit   exp_req;
    @(negedge clk);
    if (reset) begin
      mem_q.delete(); exp_q.delete();
      next_addr = RST_PC; running = 1'b1; epoch++;
      return;
    end
    exp_req = running && !redirect_valid && (mem_q.size() + exp_q.size() < DEPTH);
    checks++;
    if (imem_req !== exp_req) begin
      errors++; $display("FAIL req_gate: cyc=%0d got=%b expected=%b", cyc, imem_req, exp_req);
    end
    if (if_valid === 1'b1) begin
      checks++;
      if (if_pc4 !== if_pc + 32'd4) begin
        errors++; $display("FAIL pc4: got=%h expected=%h", if_pc4, if_pc + 32'd4);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL stale_valid: cyc=%0d if_pc=%h valid with nothing expected", cyc, if_pc);
      end
    end
    if (if_valid === 1'b1 && if_ready && !redirect_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pops++;
      checks++;
      if ({if_pc, if_instr, if_fault} !== {e.pc, e.instr, e.fault}) begin
        errors++;
        $display("FAIL pop_data: cyc=%0d got pc=%h instr=%h fault=%b expected pc=%h instr=%h fault=%b",
                 cyc, if_pc, if_instr, if_fault, e.pc, e.instr, e.fault);
      end
    end
    if (imem_rvalid && mem_q.size() != 0) begin
      r = mem_q.pop_front();
      if (!redirect_valid && r.epoch == epoch) exp_q.push_back('{r.addr, mem_word(r.addr), 1'b0});
    end
    if (imem_req === 1'b1) begin
      checks++;
      if (imem_addr !== next_addr) begin
        errors++; $display("FAIL req_addr: cyc=%0d got=%h expected=%h", cyc, imem_addr, next_addr);
      end
      mem_q.push_back('{imem_addr, cyc + lat + $urandom_range(0, jitter), epoch});
      next_addr = next_addr + 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      epoch++;
      next_addr = redirect_pc;
      running   = (redirect_pc[1:0] == 2'b00);
      if (!running) exp_q.push_back('{redirect_pc, NOP, 1'b1});
    end
  endtask

  task automatic do_reset(input int unsigned l, input int unsigned j);
    reset = 1'b1; redirect_valid = 1'b0; if_ready = 1'b0; lat = l; jitter = j;
    half(); tick(); half(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_ready = 1'b0; lat = 1; jitter = 0;
    tick(); half();
    checks++;
    if ({if_valid, if_fault, imem_req} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got valid/fault/req=%b expected=000", {if_valid, if_fault, imem_req});
    end
    checks++;
    if ({if_pc, if_pc4, if_instr} !== {RST_PC, RST_PC + 32'd4, NOP}) begin
      errors++; $display("FAIL reset_head: got pc=%h pc4=%h instr=%h", if_pc, if_pc4, if_instr);
    end
    tick();
    reset = 1'b0; if_ready = 1'b1;
    half();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC);
    end
    tick(); half();
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL early_valid: got=%b expected=0", if_valid);
    end
    tick(); half();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== RST_PC) begin
      errors++; $display("FAIL first_valid: got valid=%b pc=%h expected 1 %h", if_valid, if_pc, RST_PC);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 16; i++) begin
      tick(); half();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin
        errors++; $display("FAIL stream: got valid=%b pc=%h expected 1 %h", if_valid, if_pc, 32'(4 * i));
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset(1, 0);
    for (int i = 0; i < 10; i++) begin
      half();
      if (imem_req === 1'b1) n++;
      tick();
    end
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL bp_reqs: got=%0d expected=%0d", n, DEPTH);
    end
    if_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      half();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin
        errors++; $display("FAIL bp_drain: got valid=%b pc=%h expected 1 %h", if_valid, if_pc, 32'(4 * k));
      end
      if (k == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          errors++; $display("FAIL bp_resume: got req=%b addr=%h expected 1 00000010", imem_req, imem_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_flush();
    bit found = 1'b0;
    do_reset(3, 0);
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin half(); tick(); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    half();
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      half();
      if (if_valid === 1'b1) begin
        found = 1'b1;
        checks++;
        if (if_pc !== 32'h40) begin
          errors++; $display("FAIL flush_first: got pc=%h expected 00000040", if_pc);
        end
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL flush_timeout: got no valid expected pc 00000040");
    end
  endtask

  task automatic test_redirect_collision();
    do_reset(1, 0);
    if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin half(); tick(); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    half();
    checks++;
    if (if_valid !== 1'b1 || imem_rvalid !== 1'b1) begin
      errors++; $display("FAIL coll_setup: got valid=%b rvalid=%b expected 1 1", if_valid, imem_rvalid);
    end
    tick();
    redirect_valid = 1'b0;
    half();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL coll_after: got valid=%b req=%b addr=%h expected 0 1 00000100", if_valid, imem_req, imem_addr);
    end
    tick(); half(); tick(); half();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
      errors++; $display("FAIL coll_restart: got valid=%b pc=%h expected 1 00000100", if_valid, if_pc);
    end
    tick();
  endtask

  task automatic test_fault();
    bit found = 1'b0;
    do_reset(2, 0);
    if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin half(); tick(); end
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h42;
    half(); tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      half();
      if (if_valid === 1'b1) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || if_fault !== 1'b1 || if_pc !== 32'h42 || if_instr !== NOP) begin
      errors++; $display("FAIL fault_entry: got found=%b fault=%b pc=%h instr=%h expected 1 1 00000042 %h",
                         found, if_fault, if_pc, if_instr, NOP);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      half();
      checks++;
      if (if_valid !== 1'b1 || imem_req !== 1'b0) begin
        errors++; $display("FAIL fault_hold: got valid=%b req=%b expected 1 0", if_valid, imem_req);
      end
      tick();
    end
    if_ready = 1'b1;
    half(); tick(); half();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL fault_halt: got valid=%b req=%b expected 0 0", if_valid, imem_req);
    end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    half(); tick();
    redirect_valid = 1'b0;
    half();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      errors++; $display("FAIL fault_resume: got req=%b addr=%h expected 1 00000080", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    do_reset(1, 0);
    if_ready = 1'b1;
    half(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    half(); tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      half();
      if (imem_req === 1'b1) got.push_back(imem_addr);
      tick();
    end
    checks++;
    if (got.size() < 3 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0) begin
      errors++; $display("FAIL wrap: got %0d reqs third=%h expected 00000000 after fffffffc",
                         got.size(), (got.size() > 2) ? got[2] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2, 1);
    for (int i = 0; i < 8; i++) begin
      if_ready = ($urandom_range(0, 1) == 1);
      half(); tick();
    end
    reset = 1'b1;
    half();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got valid=%b req=%b expected 0 0", if_valid, imem_req);
    end
    tick();
    reset = 1'b0; if_ready = 1'b1;
    half();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL mid_restart: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC);
    end
    tick();
  endtask

  task automatic test_random();
    int unsigned p0;
    do_reset(1, 2);
    p0 = pops;
    for (int unsigned s = 0; s < 3; s++) begin
      lat = s + 1;
      for (int i = 0; i < 1000; i++) begin
        if_ready = ($urandom_range(0, 99) < 70);
        redirect_valid = 1'b0;
        if ($urandom_range(0, 99) < (running ? 3 : 20)) begin
          redirect_valid = 1'b1;
          redirect_pc = $urandom & 32'hFFFF_FFFC;
          if ($urandom_range(0, 9) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
        end
        half(); tick();
      end
    end
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h302;
    half(); tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || mem_q.size() != 0); i++) begin
      half(); tick();
    end
    checks++;
    if (exp_q.size() != 0 || mem_q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d entries %0d responses pending expected 0 0", exp_q.size(), mem_q.size());
    end
    checks++;
    if (pops - p0 < 200) begin
      errors++; $display("FAIL progress: got %0d pops expected at least 200", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collision();
    test_fault();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
